mult_share_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one sequential 8x8 multiplier (mult8x8) among NUM_REQ requesters.

---
 rtl/mult_share_arbiter_if.sv | 33 +++
 rtl/mult_share_arbiter.sv | 122 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// Bundle of client request/response lines and the shared multiplier's control/data lines.
// The slave modport is the arbiter side; master is the clients plus the multiplier.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   grant;
  logic                 rsp_valid;
  logic [IDX_W-1:0]     rsp_id;
  logic [15:0]          rsp_product;
  logic                 rsp_err;
  logic                 busy;
  logic [7:0]           mult_dataa;
  logic [7:0]           mult_datab;
  logic                 mult_start;
  logic                 mult_done;
  logic [15:0]          mult_product;

  modport master (
    output req, req_a, req_b, mult_done, mult_product,
    input  grant, rsp_valid, rsp_id, rsp_product, rsp_err, busy,
           mult_dataa, mult_datab, mult_start
  );

  modport slave (
    input  req, req_a, req_b, mult_done, mult_product,
    output grant, rsp_valid, rsp_id, rsp_product, rsp_err, busy,
           mult_dataa, mult_datab, mult_start
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer sharing one sequential 8x8 multiplier among NUM_REQ clients.
// Optional WAIT-state timeout abort is enabled by defining MULT_TIMEOUT_EN.
module mult_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 16
) (
  input logic                 clk,
  input logic                 reset_a,
  mult_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic             first_wait;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;

`ifdef MULT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // First pending request at or above the rr pointer, wrapping around.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(rr_ptr) + i) % NUM_REQ;
      if (!pick_found && bus.req[j]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  assign next_ptr = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      first_wait      <= 1'b0;
      bus.grant       <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= '0;
      bus.rsp_product <= '0;
      bus.busy        <= 1'b0;
      bus.mult_dataa  <= '0;
      bus.mult_datab  <= '0;
      bus.mult_start  <= 1'b0;
`ifdef MULT_TIMEOUT_EN
      wait_cnt        <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      bus.grant      <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.mult_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            bus.grant      <= GRANT_ONE << pick_idx;
            bus.mult_dataa <= bus.req_a[{pick_idx, 3'b000} +: 8];
            bus.mult_datab <= bus.req_b[{pick_idx, 3'b000} +: 8];
            bus.rsp_id     <= pick_idx;
            bus.mult_start <= 1'b1;
            bus.busy       <= 1'b1;
            rr_ptr         <= next_ptr;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          first_wait <= 1'b1;
`ifdef MULT_TIMEOUT_EN
          wait_cnt   <= CNT_W'(1);
`endif
          state      <= WAIT;
        end
        WAIT: begin
          // done in the first WAIT cycle may still belong to the previous op
          first_wait <= 1'b0;
          if (!first_wait && bus.mult_done) begin
            bus.rsp_product <= bus.mult_product;
            bus.rsp_valid   <= 1'b1;
`ifdef MULT_TIMEOUT_EN
            err_q           <= 1'b0;
`endif
            state           <= RESP;
          end
`ifdef MULT_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC)) begin
            bus.rsp_product <= 16'h0000;
            bus.rsp_valid   <= 1'b1;
            err_q           <= 1'b1;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural 4-cycle multiplier model.
// The timeout scenario runs only when MULT_TIMEOUT_EN is defined.
module tb_mult_share_arbiter;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   start_cnt = 0;
  int   rsp_cnt = 0;
  int   overlap_cnt = 0;
  int   bad_grant_cnt = 0;
  bit   in_flight = 1'b0;
  bit   force_done = 1'b0;
  bit   stuck_low = 1'b0;

  logic [2:0]  mcnt = 3'd0;
  logic        mdone = 1'b0;
  logic [15:0] mprod = 16'h0000;

  mult_share_arbiter_if #(.NUM_REQ(4), .IDX_W(2)) bus ();

  mult_share_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT_CYC(16)) dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Sequential multiplier model: done falls on start, rises 4 cycles later and then holds.
  always @(posedge clk) begin
    if (bus.mult_start) begin
      mcnt  <= 3'd4;
      mdone <= 1'b0;
    end else if (mcnt == 3'd1) begin
      mcnt  <= 3'd0;
      mdone <= 1'b1;
      mprod <= 16'(bus.mult_dataa) * 16'(bus.mult_datab);
    end else if (mcnt != 3'd0) begin
      mcnt <= mcnt - 3'd1;
    end
  end

  assign bus.mult_done    = stuck_low ? 1'b0 : (force_done ? 1'b1 : mdone);
  assign bus.mult_product = force_done ? 16'h1234 : mprod;

  always @(negedge clk) begin
    if (reset_a) begin
      in_flight = 1'b0;
    end else begin
      if (bus.grant != 4'b0000 && !$onehot(bus.grant)) bad_grant_cnt++;
      if (bus.mult_start) begin
        start_cnt++;
        if (in_flight) overlap_cnt++;
        in_flight = 1'b1;
      end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        in_flight = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output logic [3:0] g, output int gc);
    g  = 4'b0000;
    gc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.grant != 4'b0000) begin
        g  = bus.grant;
        gc = cycle;
        break;
      end
    end
    check("grant_seen", 32'(gc >= 0), 32'd1);
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        rc = cycle;
        break;
      end
    end
    check("rsp_seen", 32'(rc >= 0), 32'd1);
  endtask

  task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*idx +: 8] = a;
    bus.req_b[8*idx +: 8] = b;
  endtask

  initial begin
    logic [3:0]  g;
    int          gc, rc, s0, r0, prev_gc;
    logic [15:0] exp_prod [4];

    bus.req   = 4'b0000;
    bus.req_a = '0;
    bus.req_b = '0;
    $display("[TB] reset");
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_start", 32'(bus.mult_start), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_product", 32'(bus.rsp_product), 32'h0);
    check("rst_dataa", 32'(bus.mult_dataa), 32'h0);
    reset_a = 1'b0;

    // 1: single op on client 2, operands changed after grant
    $display("[TB] single op");
    s0 = start_cnt;
    set_ops(2, 8'hFF, 8'hFF);
    bus.req = 4'b0100;
    wait_grant(g, gc);
    bus.req = 4'b0000;
    set_ops(2, 8'h00, 8'h00);
    check("t1_grant", 32'(g), 32'h4);
    check("t1_start_with_grant", 32'(bus.mult_start), 32'h1);
    check("t1_busy", 32'(bus.busy), 32'h1);
    check("t1_dataa", 32'(bus.mult_dataa), 32'hFF);
    wait_rsp(rc);
    check("t1_latency", 32'(rc - gc), 32'd6);
    check("t1_rsp_id", 32'(bus.rsp_id), 32'h2);
    check("t1_product", 32'(bus.rsp_product), 32'hFE01);
    check("t1_err", 32'(bus.rsp_err), 32'h0);
    check("t1_starts", 32'(start_cnt - s0), 32'd1);
    @(negedge clk);
    check("t1_valid_drop", 32'(bus.rsp_valid), 32'h0);
    check("t1_product_hold", 32'(bus.rsp_product), 32'hFE01);
    check("t1_idle_busy", 32'(bus.busy), 32'h0);

    // 2: all four clients held high from reset
    $display("[TB] all clients");
    reset_a = 1'b1;
    set_ops(0, 8'h03, 8'h05); exp_prod[0] = 16'h000F;
    set_ops(1, 8'h0A, 8'h14); exp_prod[1] = 16'h00C8;
    set_ops(2, 8'h80, 8'h02); exp_prod[2] = 16'h0100;
    set_ops(3, 8'hFF, 8'h01); exp_prod[3] = 16'h00FF;
    bus.req = 4'b1111;
    @(negedge clk);
    reset_a = 1'b0;
    prev_gc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, gc);
      if (n == 4) bus.req = 4'b0000;
      check("t2_grant", 32'(g), 32'(4'b0001 << (n % 4)));
      if (n == 1) check("t2_grant_gap_ge4", 32'(gc - prev_gc >= 4), 32'd1);
      prev_gc = gc;
      wait_rsp(rc);
      check("t2_rsp_id", 32'(bus.rsp_id), 32'(n % 4));
      check("t2_product", 32'(bus.rsp_product), 32'(exp_prod[n % 4]));
    end
    check("t2_no_overlap", 32'(overlap_cnt), 32'd0);
    check("t2_onehot", 32'(bad_grant_cnt), 32'd0);

    // 3: client 1 re-requests right after its own grant, client 3 waiting
    $display("[TB] round robin");
    set_ops(1, 8'h02, 8'h02);
    set_ops(3, 8'h10, 8'h10);
    bus.req = 4'b0010;
    wait_grant(g, gc);
    bus.req = 4'b1010;
    check("t3_first", 32'(g), 32'h2);
    wait_rsp(rc);
    wait_grant(g, gc);
    bus.req = 4'b0010;
    check("t3_second", 32'(g), 32'h8);
    wait_rsp(rc);
    check("t3_second_product", 32'(bus.rsp_product), 32'h0100);
    wait_grant(g, gc);
    bus.req = 4'b0000;
    check("t3_third", 32'(g), 32'h2);
    wait_rsp(rc);
    check("t3_third_id", 32'(bus.rsp_id), 32'h1);

    // 4: reset during WAIT drops the op
    $display("[TB] reset mid-op");
    set_ops(0, 8'h07, 8'h09);
    bus.req = 4'b0001;
    wait_grant(g, gc);
    bus.req = 4'b0000;
    check("t4_grant", 32'(g), 32'h1);
    @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    r0 = rsp_cnt;
    check("t4_busy", 32'(bus.busy), 32'h0);
    check("t4_rsp_id", 32'(bus.rsp_id), 32'h0);
    check("t4_product", 32'(bus.rsp_product), 32'h0);
    check("t4_dataa", 32'(bus.mult_dataa), 32'h0);
    reset_a = 1'b0;
    s0 = start_cnt;
    repeat (10) @(negedge clk);
    check("t4_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    check("t4_no_start", 32'(start_cnt - s0), 32'd0);
    set_ops(2, 8'h02, 8'h03);
    bus.req = 4'b0100;
    wait_grant(g, gc);
    bus.req = 4'b0000;
    check("t4_new_grant", 32'(g), 32'h4);
    wait_rsp(rc);
    check("t4_new_product", 32'(bus.rsp_product), 32'h0006);
    check("t4_new_starts", 32'(start_cnt - s0), 32'd1);

    // 5: done already high when the op starts
    $display("[TB] stale done");
    force_done = 1'b1;
    set_ops(0, 8'h01, 8'h01);
    bus.req = 4'b0001;
    wait_grant(g, gc);
    bus.req = 4'b0000;
    check("t5_grant", 32'(g), 32'h1);
    wait_rsp(rc);
    check("t5_latency", 32'(rc - gc), 32'd3);
    check("t5_product", 32'(bus.rsp_product), 32'h1234);
    force_done = 1'b0;
    @(negedge clk);

`ifdef MULT_TIMEOUT_EN
    // 6: multiplier never finishes
    $display("[TB] timeout");
    stuck_low = 1'b1;
    set_ops(1, 8'h05, 8'h05);
    bus.req = 4'b0010;
    wait_grant(g, gc);
    bus.req = 4'b0000;
    check("t6_grant", 32'(g), 32'h2);
    wait_rsp(rc);
    check("t6_latency", 32'(rc - gc), 32'd17);
    check("t6_err", 32'(bus.rsp_err), 32'h1);
    check("t6_product", 32'(bus.rsp_product), 32'h0);
    stuck_low = 1'b0;
    set_ops(2, 8'h03, 8'h04);
    bus.req = 4'b0100;
    wait_grant(g, gc);
    bus.req = 4'b0000;
    check("t6_next_grant", 32'(g), 32'h4);
    wait_rsp(rc);
    check("t6_next_latency", 32'(rc - gc), 32'd6);
    check("t6_next_err", 32'(bus.rsp_err), 32'h0);
    check("t6_next_product", 32'(bus.rsp_product), 32'h000C);
`endif

    check("end_no_overlap", 32'(overlap_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
